// File: rtl/instr_encoder.sv
// Program loader: encodes MIPS instruction field tuples into 32-bit words and writes them to imem.
// Optional macro SHAMT_FIELD_EN adds an in_shamt port that fills R-type bits [10:6].
module instr_encoder #(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
`ifdef SHAMT_FIELD_EN
  input  logic [4:0]        in_shamt,
`endif
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    K_RTYPE = 3'd0,
    K_LW    = 3'd1,
    K_SW    = 3'd2,
    K_BEQ   = 3'd3,
    K_ADDI  = 3'd4,
    K_J     = 3'd5
  } kind_t;

  localparam logic [ADDR_W-1:0] BASE      = BASE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t      state;
  logic        last_q;
  logic [4:0]  shamt;
  logic [31:0] enc_word;
  logic        enc_legal;

`ifdef SHAMT_FIELD_EN
  assign shamt = in_shamt;
`else
  assign shamt = 5'd0;
`endif

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    enc_word  = 32'd0;
    enc_legal = 1'b1;
    case (in_kind)
      K_RTYPE: enc_word = {6'b000000, in_rs, in_rt, in_rd, shamt, in_funct};
      K_LW:    enc_word = {6'b100011, in_rs, in_rt, in_imm};
      K_SW:    enc_word = {6'b101011, in_rs, in_rt, in_imm};
      K_BEQ:   enc_word = {6'b000100, in_rs, in_rt, in_imm};
      K_ADDI:  enc_word = {6'b001000, in_rs, in_rt, in_imm};
      K_J:     enc_word = {6'b000010, in_target};
      default: enc_legal = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE;
      imem_wdata <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      count      <= '0;
      last_q     <= 1'b0;
    end else if (start) begin
      // Restart wins over any state; a tuple offered this cycle is dropped.
      state     <= LOAD;
      in_ready  <= 1'b1;
      imem_we   <= 1'b0;
      imem_addr <= BASE;
      busy      <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b0;
          imem_we  <= 1'b0;
        end
        LOAD: begin
          if (in_valid && in_ready) begin
            if (enc_legal) begin
              state      <= WRITE;
              in_ready   <= 1'b0;
              imem_we    <= 1'b1;
              imem_wdata <= enc_word;
              last_q     <= in_last;
            end else begin
              err <= 1'b1;
              if (in_last) begin
                state    <= DONE;
                in_ready <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
              end
            end
          end
        end
        WRITE: begin
          imem_we   <= 1'b0;
          imem_addr <= imem_addr + 1'b1;
          if (count != COUNT_MAX) count <= count + 1'b1;
          if (last_q || imem_addr == LAST_ADDR) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (!last_q) err <= 1'b1;
          end else begin
            state    <= LOAD;
            in_ready <= 1'b1;
          end
        end
        DONE: begin
          in_ready <= 1'b0;
          imem_we  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a default-size instance plus an ADDR_W=2 instance for overflow.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_last;
  logic [2:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  logic        in_ready, imem_we, busy, done, err;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [6:0]  count;

  logic        in_ready2, imem_we2, busy2, done2, err2;
  logic [1:0]  imem_addr2;
  logic [31:0] imem_wdata2;
  logic [2:0]  count2;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(6), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target),
`ifdef SHAMT_FIELD_EN
    .in_shamt(5'd0),
`endif
    .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .count(count)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target),
`ifdef SHAMT_FIELD_EN
    .in_shamt(5'd0),
`endif
    .in_last(in_last), .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
    .busy(busy2), .done(done2), .err(err2), .count(count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tuple(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm,
                           input logic [25:0] tgt, input logic last);
    in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_funct = fn;
    in_imm = imm; in_target = tgt; in_last = last;
  endtask

  // One handshake from LOAD, then the WRITE cycle is checked against the expected word.
  task automatic send(input string tag, input logic [2:0] k, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn,
                      input logic [15:0] imm, input logic [25:0] tgt, input logic last,
                      input logic [5:0] exp_addr, input logic [31:0] exp_word);
    check({tag, " ready"}, {31'd0, in_ready}, 32'd1);
    set_tuple(k, rs, rt, rd, fn, imm, tgt, last);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, " we"},    {31'd0, imem_we}, 32'd1);
    check({tag, " addr"},  {26'd0, imem_addr}, {26'd0, exp_addr});
    check({tag, " wdata"}, imem_wdata, exp_word);
    tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    set_tuple(3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
    tick(); tick();
    reset = 1'b0;

    // Reset values
    check("rst in_ready", {31'd0, in_ready}, 32'd0);
    check("rst we",       {31'd0, imem_we},  32'd0);
    check("rst addr",     {26'd0, imem_addr}, 32'd0);
    check("rst wdata",    imem_wdata, 32'd0);
    check("rst busy",     {31'd0, busy}, 32'd0);
    check("rst done",     {31'd0, done}, 32'd0);
    check("rst err",      {31'd0, err},  32'd0);
    check("rst count",    {25'd0, count}, 32'd0);
    tick();
    check("idle ready", {31'd0, in_ready}, 32'd0);

    // First R-type word
    do_start();
    check("load busy", {31'd0, busy}, 32'd1);
    send("rtype", 3'd0, 5'd1, 5'd2, 5'd3, 6'b100000, 16'd0, 26'd0, 1'b0, 6'd0, 32'h00221820);
    check("rtype count", {25'd0, count}, 32'd1);
    check("rtype ready", {31'd0, in_ready}, 32'd1);
    check("rtype we0",   {31'd0, imem_we}, 32'd0);

    // Consecutive program ending in j with in_last
    do_start();
    send("lw",   3'd1, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b0, 6'd0, 32'h8C220004);
    send("sw",   3'd2, 5'd0, 5'd2, 5'd0, 6'd0, 16'h0008, 26'd0, 1'b0, 6'd1, 32'hAC020008);
    send("beq",  3'd3, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0, 6'd2, 32'h1022FFFF);
    send("addi", 3'd4, 5'd0, 5'd1, 5'd0, 6'd0, 16'h0005, 26'd0, 1'b0, 6'd3, 32'h20010005);
    send("j",    3'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 1'b1, 6'd4, 32'h08000010);
    check("prog done",  {31'd0, done}, 32'd1);
    check("prog count", {25'd0, count}, 32'd5);
    check("prog ready", {31'd0, in_ready}, 32'd0);
    check("prog busy",  {31'd0, busy}, 32'd0);
    check("prog err",   {31'd0, err}, 32'd0);
    tick();
    check("done hold", {31'd0, done}, 32'd1);

    // Illegal kind: err set, nothing written, address held
    do_start();
    check("start clr done", {31'd0, done}, 32'd0);
    set_tuple(3'd7, 5'd1, 5'd1, 5'd1, 6'd1, 16'd1, 26'd1, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("ill err",   {31'd0, err}, 32'd1);
    check("ill we",    {31'd0, imem_we}, 32'd0);
    check("ill addr",  {26'd0, imem_addr}, 32'd0);
    check("ill count", {25'd0, count}, 32'd0);
    send("ill next", 3'd4, 5'd2, 5'd3, 5'd0, 6'd0, 16'h0010, 26'd0, 1'b0, 6'd0, 32'h20430010);
    check("ill sticky", {31'd0, err}, 32'd1);
    do_start();
    check("start clr err", {31'd0, err}, 32'd0);

    // Capacity overflow on the ADDR_W=2 instance
    do_start();
    for (int i = 0; i < 4; i++) begin
      check("ovf ready", {31'd0, in_ready2}, 32'd1);
      set_tuple(3'd4, 5'd0, 5'd1, 5'd0, 6'd0, 16'(i), 26'd0, 1'b0);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("ovf we",    {31'd0, imem_we2}, 32'd1);
      check("ovf addr",  {30'd0, imem_addr2}, 32'(i));
      check("ovf wdata", imem_wdata2, 32'h20010000 | 32'(i));
      tick();
    end
    check("ovf err",   {31'd0, err2}, 32'd1);
    check("ovf done",  {31'd0, done2}, 32'd1);
    check("ovf count", {29'd0, count2}, 32'd4);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("ovf 5th ready", {31'd0, in_ready2}, 32'd0);
      tick();
      check("ovf 5th we",    {31'd0, imem_we2}, 32'd0);
    end
    in_valid = 1'b0;
    check("ovf count hold", {29'd0, count2}, 32'd4);

    // start together with a LOAD handshake drops the tuple
    do_start();
    send("pre", 3'd0, 5'd4, 5'd5, 5'd6, 6'b100010, 16'd0, 26'd0, 1'b0, 6'd0, 32'h00853022);
    check("pre addr", {26'd0, imem_addr}, 32'd1);
    set_tuple(3'd1, 5'd1, 5'd1, 5'd1, 6'd0, 16'd1, 26'd0, 1'b0);
    in_valid = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    check("sh we",    {31'd0, imem_we}, 32'd0);
    check("sh addr",  {26'd0, imem_addr}, 32'd0);
    check("sh count", {25'd0, count}, 32'd0);
    check("sh ready", {31'd0, in_ready}, 32'd1);

    // Reset during WRITE abandons the write
    set_tuple(3'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h3FF, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("rw we1", {31'd0, imem_we}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rw we0",    {31'd0, imem_we}, 32'd0);
    check("rw addr",   {26'd0, imem_addr}, 32'd0);
    check("rw wdata",  imem_wdata, 32'd0);
    check("rw count",  {25'd0, count}, 32'd0);
    check("rw busy",   {31'd0, busy}, 32'd0);
    check("rw ready",  {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("rw idle ready", {31'd0, in_ready}, 32'd0);
    check("rw idle we",    {31'd0, imem_we}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Program loader for the single-cycle MIPS core. It is the inverse of the control path's decode: it takes instruction fields (kind, registers, funct, immediate, target), encodes them into 32-bit MIPS machine words, and writes them into instruction memory at consecutive word addresses. Used by benches and the boot path to fill imem before the core runs. A valid/ready handshake throttles the field source. An FSM sequences start, load, write and done.

Parameters:
ADDR_W, 6, instruction-memory word-address width; capacity is 2^ADDR_W words.
BASE_ADDR, 0, first word address written after start.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  begin a new program load; restarts from any state
in_valid  input  1  field tuple valid
in_ready  output  1  encoder accepts a tuple this cycle
in_kind  input  3  0=R-type, 1=lw, 2=sw, 3=beq, 4=addi, 5=j, 6/7=illegal
in_rs  input  5  rs field
in_rt  input  5  rt field
in_rd  input  5  rd field (R-type only)
in_funct  input  6  funct field (R-type only)
in_imm  input  16  immediate/offset (lw, sw, beq, addi)
in_target  input  26  jump target (j)
in_last  input  1  this tuple is the final instruction
imem_we  output  1  instruction-memory write strobe
imem_addr  output  ADDR_W  write word address
imem_wdata  output  32  encoded instruction
busy  output  1  high in LOAD and WRITE
done  output  1  load finished; held until start
err  output  1  sticky: illegal kind or capacity overflow
count  output  ADDR_W+1  number of words written since start

Behaviour:
- Reset: state IDLE. in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, busy=0, done=0, err=0, count=0.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE: in_ready=0. On start, go to LOAD.
- LOAD: in_ready=1. A handshake (in_valid & in_ready) registers the encoded word and in_last.
  - Legal kind: go to WRITE.
  - Illegal kind (6/7): set err. Nothing is written, address and count do not advance, and the FSM stays in LOAD. If in_last is set, go to DONE instead.
- WRITE: lasts exactly one cycle. imem_we=1, imem_wdata=registered word, in_ready=0. At the end of the cycle, imem_addr increments and count increments.
  - in_last set: go to DONE.
  - Otherwise, if imem_addr was 2^ADDR_W-1: set err (overflow) and go to DONE.
  - Otherwise: go to LOAD.
- DONE: done=1, in_ready=0. Hold until start.
- Latency and throughput: a handshake in cycle N gives imem_we=1 in cycle N+1. Maximum rate is one word per 2 cycles.
- imem_we=0 in every state except WRITE. imem_wdata holds its last value.
- start has priority over everything in any state, including LOAD with a simultaneous handshake (that tuple is dropped) and WRITE (that write still occurs this cycle).
  - Next state is LOAD.
  - imem_addr=BASE_ADDR, count=0, err=0, done=0.
- reset mid-operation: return to reset values next edge. An in-flight write is abandoned, so imem_we=0 after the edge.
- imem_addr wraps modulo 2^ADDR_W. count saturates at 2^ADDR_W.
- Encoding, bits [31:26] opcode:
  - R-type: {000000, rs, rt, rd, 00000, funct}
  - lw: {100011, rs, rt, imm}
  - sw: {101011, rs, rt, imm}
  - beq: {000100, rs, rt, imm}
  - addi: {001000, rs, rt, imm}
  - j: {000010, target}
  - Unused inputs are ignored.

Optional Feature:
SHAMT_FIELD_EN:
- Defined: adds port in_shamt (input, 5 bits). R-type bits [10:6] = in_shamt.
- Undefined: port absent; R-type bits [10:6] are always 0.

Test Plan:
- reset, then start; R-type rs=1 rt=2 rd=3 funct=100000 with in_last=0 -> next cycle imem_we=1, addr=0, wdata=0x00221820; count=1, back in LOAD.
- Consecutive tuples: lw rs=1 rt=2 imm=4; sw rs=0 rt=2 imm=8; beq rs=1 rt=2 imm=0xFFFF; addi rs=0 rt=1 imm=5; j target=0x10 with in_last=1 -> writes at addr 0..4 of 0x8C220004, 0xAC020008, 0x1022FFFF, 0x20010005, 0x08000010; done=1, count=5, in_ready=0.
- in_kind=7 during load -> err=1, no imem_we, addr unchanged. Next legal tuple is written at the same address; err stays 1 until start.
- ADDR_W=2: 5 tuples none with in_last -> 4 writes at addr 0..3, then err=1, done=1, count=4. The 5th tuple is never accepted.
- start asserted together with a LOAD handshake -> tuple dropped, no imem_we next cycle, addr=BASE_ADDR, count=0.
- reset asserted in WRITE -> imem_we=0 next cycle, all outputs at reset values, state IDLE (in_ready=0 until start).
